psr_file: RTL and testbench

Program status register file for the ARM core. It holds the CPSR with ARM-layout NZCV flags, I/F masks and a 5-bit mode field, plus the saved PSRs (SPSRs) used on exception entry and return. Flags are computed from an ALU result of parametrised width, with a per-flag update mask. The block sits beside the register bank and the ALU, and is driven by the decode/execute control.

---
 rtl/psr_file_if.sv | 55 +++++
 rtl/psr_file.sv | 212 +++++++++++++++++++++
 tb/tb_psr_file.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psr_file_if.sv
// psr_file_if
// Bundles the request and status signals of the ARM program status register
// file. The RTL block connects through the slave modport. Decode/execute
// control, or a testbench, connects through the master modport.
//
// Signals (direction as seen by the PSR file):
//   flag_we      in   update flags from the ALU result this cycle
//   flag_mask    in   per-flag enable {N,Z,C,V}
//   result       in   ALU result, DATA_W bits
//   cin, vin     in   ALU carry / overflow
//   msr_we       in   MSR write
//   msr_spsr     in   MSR target: 0 = CPSR, 1 = SPSR of the current mode
//   msr_field    in   byte enables: [1] flags byte, [0] control byte
//   msr_data     in   MSR write data
//   exc_req      in   exception entry
//   exc_mode     in   target mode of the exception
//   exc_fiq_dis  in   also set F on entry
//   eret         in   exception return
//   cpsr         out  current CPSR
//   spsr         out  SPSR of the current mode (0 in USR/SYS)
//   err          out  one-cycle pulse after an illegal request
interface psr_file_if #(
  parameter int DATA_W = 32
);
  logic              flag_we;
  logic [3:0]        flag_mask;
  logic [DATA_W-1:0] result;
  logic              cin;
  logic              vin;
  logic              msr_we;
  logic              msr_spsr;
  logic [1:0]        msr_field;
  logic [31:0]       msr_data;
  logic              exc_req;
  logic [4:0]        exc_mode;
  logic              exc_fiq_dis;
  logic              eret;
  logic [31:0]       cpsr;
  logic [31:0]       spsr;
  logic              err;

  modport master (
    output flag_we, flag_mask, result, cin, vin,
    output msr_we, msr_spsr, msr_field, msr_data,
    output exc_req, exc_mode, exc_fiq_dis, eret,
    input  cpsr, spsr, err
  );

  modport slave (
    input  flag_we, flag_mask, result, cin, vin,
    input  msr_we, msr_spsr, msr_field, msr_data,
    input  exc_req, exc_mode, exc_fiq_dis, eret,
    output cpsr, spsr, err
  );
endinterface

// File: rtl/psr_file.sv
// psr_file
// Program status register file for the ARM core. It holds the CPSR, which
// contains the NZCV flags, the I/F masks and the 5-bit mode, together with
// the saved PSRs. The saved PSRs are written on exception entry and are
// restored on exception return. Every update lands on the clock edge after
// the request, so the latency is 1 cycle. The priority order is
// rst > exc_req > eret > msr_we > flag_we.
//
// Configuration macro: PSR_BANKED_SPSR_EN
//   defined     -> five SPSRs (FIQ, IRQ, SVC, ABT, UND), selected by mode
//   not defined -> one SPSR, shared by every mode that owns an SPSR
//
// Parameters:
//   DATA_W      width of the ALU result that N and Z come from (>= 8)
//   RESET_MODE  mode field loaded by reset (SVC by default)
//
// Ports:
//   clk   in   clock; all state changes on the rising edge
//   rst   in   synchronous, active-high reset
//   bus   psr_file_if.slave, which carries the requests and cpsr/spsr/err
module psr_file #(
  parameter int         DATA_W     = 32,
  parameter logic [4:0] RESET_MODE = 5'h13
) (
  input logic       clk,
  input logic       rst,
  psr_file_if.slave bus
);

  localparam logic [4:0] MODE_USR = 5'h10;
  localparam logic [4:0] MODE_FIQ = 5'h11;
  localparam logic [4:0] MODE_IRQ = 5'h12;
  localparam logic [4:0] MODE_SVC = 5'h13;
  localparam logic [4:0] MODE_ABT = 5'h17;
  localparam logic [4:0] MODE_UND = 5'h1B;
  localparam logic [4:0] MODE_SYS = 5'h1F;

`ifdef PSR_BANKED_SPSR_EN
  localparam int NBANK = 5;
`else
  localparam int NBANK = 1;
`endif

  function automatic logic mode_valid(input logic [4:0] m);
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Modes that own an SPSR. USR, SYS and illegal encodings do not.
  function automatic logic mode_has_spsr(input logic [4:0] m);
    case (m)
      MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

`ifdef PSR_BANKED_SPSR_EN
  function automatic int bank_idx(input logic [4:0] m);
    case (m)
      MODE_FIQ: return 0;
      MODE_IRQ: return 1;
      MODE_SVC: return 2;
      MODE_ABT: return 3;
      default:  return 4;
    endcase
  endfunction
`endif

  // Returns true when mode m owns SPSR storage slot b. With a single shared
  // SPSR, slot 0 belongs to every mode that owns an SPSR.
  function automatic logic bank_hit(input logic [4:0] m, input int b);
`ifdef PSR_BANKED_SPSR_EN
    return mode_has_spsr(m) && (bank_idx(m) == b);
`else
    return mode_has_spsr(m) && (b == 0);
`endif
  endfunction

  function automatic logic [31:0] psr_pack(input logic [3:0] flags,
                                           input logic       i_bit,
                                           input logic       f_bit,
                                           input logic [4:0] mode);
    return {flags, 20'h0, i_bit, f_bit, 1'b0, mode};
  endfunction

  // Merges an MSR write into a stored SPSR one byte at a time. Only the
  // defined bits are taken. An illegal mode in the control byte leaves the
  // stored mode unchanged.
  function automatic logic [31:0] msr_merge(input logic [31:0] old,
                                            input logic [31:0] data,
                                            input logic [1:0]  field);
    logic [31:0] res;
    res = old;
    if (field[1]) res[31:28] = data[31:28];
    if (field[0]) begin
      res[7:6] = data[7:6];
      if (mode_valid(data[4:0])) res[4:0] = data[4:0];
    end
    return res;
  endfunction

  logic [3:0]  r_flags;
  logic        r_i;
  logic        r_f;
  logic [4:0]  r_mode;
  logic        r_err;
  logic [31:0] r_spsr [NBANK];

  logic [3:0]  w_flags_nxt;
  logic        w_i_nxt;
  logic        w_f_nxt;
  logic [4:0]  w_mode_nxt;
  logic        w_err_nxt;
  logic [31:0] w_spsr_nxt [NBANK];
  logic [31:0] w_cpsr;
  logic [31:0] w_spsr_cur;
  logic        w_res_zero;

  assign w_cpsr     = psr_pack(r_flags, r_i, r_f, r_mode);
  assign w_res_zero = (bus.result == '0);

  // spsr is a combinational view, selected by the registered mode.
  always_comb begin
    w_spsr_cur = 32'h0;
    for (int b = 0; b < NBANK; b++) begin
      if (bank_hit(r_mode, b)) w_spsr_cur = r_spsr[b];
    end
  end

  always_comb begin
    w_flags_nxt = r_flags;
    w_i_nxt     = r_i;
    w_f_nxt     = r_f;
    w_mode_nxt  = r_mode;
    w_err_nxt   = 1'b0;
    for (int b = 0; b < NBANK; b++) w_spsr_nxt[b] = r_spsr[b];

    if (bus.exc_req) begin
      if (mode_has_spsr(bus.exc_mode)) begin
        for (int b = 0; b < NBANK; b++) begin
          if (bank_hit(bus.exc_mode, b)) w_spsr_nxt[b] = w_cpsr;
        end
        w_mode_nxt = bus.exc_mode;
        w_i_nxt    = 1'b1;
        if (bus.exc_fiq_dis) w_f_nxt = 1'b1;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (bus.eret) begin
      if (mode_has_spsr(r_mode)) begin
        w_flags_nxt = w_spsr_cur[31:28];
        w_i_nxt     = w_spsr_cur[7];
        w_f_nxt     = w_spsr_cur[6];
        // A corrupt saved mode (for example the all-zero reset SPSR) drops
        // the core to USR and does not leave it in an undefined mode.
        w_mode_nxt  = mode_valid(w_spsr_cur[4:0]) ? w_spsr_cur[4:0] : MODE_USR;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (bus.msr_we) begin
      if (bus.msr_spsr) begin
        if (mode_has_spsr(r_mode)) begin
          for (int b = 0; b < NBANK; b++) begin
            if (bank_hit(r_mode, b))
              w_spsr_nxt[b] = msr_merge(r_spsr[b], bus.msr_data, bus.msr_field);
          end
        end else begin
          w_err_nxt = 1'b1;
        end
      end else begin
        if (bus.msr_field[1]) w_flags_nxt = bus.msr_data[31:28];
        // User code may change only the flags byte of the CPSR.
        if (bus.msr_field[0] && (r_mode != MODE_USR)) begin
          w_i_nxt = bus.msr_data[7];
          w_f_nxt = bus.msr_data[6];
          if (mode_valid(bus.msr_data[4:0])) w_mode_nxt = bus.msr_data[4:0];
        end
      end
    end else if (bus.flag_we) begin
      if (bus.flag_mask[3]) w_flags_nxt[3] = bus.result[DATA_W-1];
      if (bus.flag_mask[2]) w_flags_nxt[2] = w_res_zero;
      if (bus.flag_mask[1]) w_flags_nxt[1] = bus.cin;
      if (bus.flag_mask[0]) w_flags_nxt[0] = bus.vin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 4'h0;
      r_i     <= 1'b1;
      r_f     <= 1'b1;
      r_mode  <= RESET_MODE;
      r_err   <= 1'b0;
      for (int b = 0; b < NBANK; b++) r_spsr[b] <= 32'h0;
    end else begin
      r_flags <= w_flags_nxt;
      r_i     <= w_i_nxt;
      r_f     <= w_f_nxt;
      r_mode  <= w_mode_nxt;
      r_err   <= w_err_nxt;
      for (int b = 0; b < NBANK; b++) r_spsr[b] <= w_spsr_nxt[b];
    end
  end

  assign bus.cpsr = w_cpsr;
  assign bus.spsr = w_spsr_cur;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_psr_file.sv
module tb_psr_file;

  localparam int DATA_W = 32;

  typedef struct {
    int          cyc;
    logic [31:0] cpsr;
    logic [31:0] spsr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stim_done = 1'b0;
  exp_t q[$];

  psr_file_if #(.DATA_W(DATA_W)) bus ();

  psr_file #(.DATA_W(DATA_W), .RESET_MODE(5'h13)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: the architectural state is held as whole 32-bit words,
  // and each saved PSR is kept in an array indexed by its owning mode.
  logic [31:0] m_cpsr;
  logic [31:0] m_spsr [0:31];
  logic        m_err;
  logic [31:0] m_spsr_out;

  function automatic bit m_valid(input logic [4:0] m);
    return m inside {5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
  endfunction

  function automatic bit m_priv(input logic [4:0] m);
    return m inside {5'h11, 5'h12, 5'h13, 5'h17, 5'h1B};
  endfunction

  function automatic int m_key(input logic [4:0] m);
`ifdef PSR_BANKED_SPSR_EN
    return int'(m);
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    logic [31:0] nc, mask, s;
    logic [3:0]  nzcv;
    logic [4:0]  md;
    nc = m_cpsr; m_err = 1'b0; md = m_cpsr[4:0];
    if (rst) begin
      nc = 32'h0000_00C0 | 32'h13;
      for (int k = 0; k < 32; k++) m_spsr[k] = 32'h0;
    end else if (bus.exc_req) begin
      if (m_priv(bus.exc_mode)) begin
        m_spsr[m_key(bus.exc_mode)] = m_cpsr;
        nc = (m_cpsr & 32'hF000_0040) | 32'h80 | {27'h0, bus.exc_mode}
             | (bus.exc_fiq_dis ? 32'h40 : 32'h0);
      end else m_err = 1'b1;
    end else if (bus.eret) begin
      if (m_priv(md)) begin
        s = m_spsr[m_key(md)];
        nc = s;
        if (!m_valid(s[4:0])) nc[4:0] = 5'h10;
      end else m_err = 1'b1;
    end else if (bus.msr_we) begin
      mask = (bus.msr_field[1] ? 32'hF000_0000 : 32'h0);
      if (bus.msr_field[0]) mask |= 32'hC0 | (m_valid(bus.msr_data[4:0]) ? 32'h1F : 32'h0);
      if (bus.msr_spsr) begin
        if (m_priv(md))
          m_spsr[m_key(md)] = (m_spsr[m_key(md)] & ~mask) | (bus.msr_data & mask);
        else m_err = 1'b1;
      end else begin
        if (md == 5'h10) mask &= 32'hF000_0000;
        nc = (nc & ~mask) | (bus.msr_data & mask);
      end
    end else if (bus.flag_we) begin
      nzcv = {bus.result[DATA_W-1], (bus.result == 0), bus.cin, bus.vin};
      mask = {bus.flag_mask, 28'h0};
      nc = (nc & ~mask) | ({nzcv, 28'h0} & mask);
    end
    m_cpsr = nc;
    m_spsr_out = m_priv(nc[4:0]) ? m_spsr[m_key(nc[4:0])] : 32'h0;
  endtask

  task automatic idle();
    bus.flag_we = 0; bus.flag_mask = 0; bus.result = 0; bus.cin = 0; bus.vin = 0;
    bus.msr_we = 0; bus.msr_spsr = 0; bus.msr_field = 0; bus.msr_data = 0;
    bus.exc_req = 0; bus.exc_mode = 0; bus.exc_fiq_dis = 0; bus.eret = 0;
    rst = 0;
  endtask

  // Applies the inputs already set up, pushes the expected state for the next
  // edge (taken from a spec constant when one is supplied), and steps one cycle.
  task automatic step(input bit chk_c = 0, input logic [31:0] cc = 0,
                      input bit chk_s = 0, input logic [31:0] cs = 0);
    exp_t it;
    model_step();
    it.cyc  = edge_cnt + 1;
    it.cpsr = chk_c ? cc : m_cpsr;
    it.spsr = chk_s ? cs : m_spsr_out;
    it.err  = m_err;
    q.push_back(it);
    @(posedge clk); #1;
  endtask

  task automatic cmp(input string name, input int cyc,
                     input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor: after each edge, checks every expectation that is due.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
        it = q.pop_front();
        if (it.cyc != edge_cnt) begin
          n_cmp++; n_bad++;
          $display("FAIL stale_entry cyc=%0d got=%0d expected=%0d", it.cyc, edge_cnt, it.cyc);
        end else begin
          cmp("cpsr", it.cyc, bus.cpsr, it.cpsr);
          cmp("spsr", it.cyc, bus.spsr, it.spsr);
          cmp("err",  it.cyc, {31'h0, bus.err}, {31'h0, it.err});
        end
      end
    end
  end

  initial begin
    logic [4:0] modes [7];
    modes = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
    idle(); rst = 1;
    m_cpsr = 32'h0; m_err = 0; m_spsr_out = 0;
    for (int k = 0; k < 32; k++) m_spsr[k] = 32'h0;
    @(negedge clk);

    // Reset
    step(1, 32'h0000_00D3, 1, 32'h0);
    // Flags: full mask, then N only
    idle(); bus.flag_we = 1; bus.flag_mask = 4'b1111; bus.result = 0; bus.cin = 1;
    step(1, 32'h6000_00D3, 1, 32'h0);
    idle(); bus.flag_we = 1; bus.flag_mask = 4'b1000; bus.result = 32'h8000_0000;
    step(1, 32'hE000_00D3);
    // Flags to 4'b1010 through MSR (flags byte only)
    idle(); bus.msr_we = 1; bus.msr_field = 2'b10; bus.msr_data = 32'hA000_0000;
    step(1, 32'hA000_00D3);
    // Exception round trip SVC -> IRQ -> SVC (F held at 1 from reset)
    idle(); bus.exc_req = 1; bus.exc_mode = 5'h12;
    step(1, 32'hA000_00D2, 1, 32'hA000_00D3);
    idle(); bus.eret = 1;
    step(1, 32'hA000_00D3);
    // Banking sequence
    idle(); bus.exc_req = 1; bus.exc_mode = 5'h12;
    step(1, 32'hA000_00D2, 1, 32'hA000_00D3);
    idle(); bus.msr_we = 1; bus.msr_spsr = 1; bus.msr_field = 2'b11; bus.msr_data = 32'h10;
    step(1, 32'hA000_00D2, 1, 32'h0000_0010);
    idle(); bus.exc_req = 1; bus.exc_mode = 5'h11;
    step(1, 32'hA000_00D1, 1, 32'hA000_00D2);
    idle(); bus.eret = 1;
`ifdef PSR_BANKED_SPSR_EN
    step(1, 32'hA000_00D2, 1, 32'h0000_0010);
`else
    step(1, 32'hA000_00D2, 1, 32'hA000_00D2);
`endif
    // Privilege: drop to USR, then MSR in USR, eret in USR, SPSR MSR in USR
    idle(); bus.msr_we = 1; bus.msr_field = 2'b01; bus.msr_data = 32'h10;
    step(1, 32'hA000_0010, 1, 32'h0);
    idle(); bus.msr_we = 1; bus.msr_field = 2'b11; bus.msr_data = 32'hF000_00D3;
    step(1, 32'hF000_0010);
    idle(); bus.eret = 1;
    step(1, 32'hF000_0010);
    idle(); bus.msr_we = 1; bus.msr_spsr = 1; bus.msr_field = 2'b11; bus.msr_data = 32'hFFFF_FFFF;
    step(1, 32'hF000_0010);
    idle(); bus.exc_req = 1; bus.exc_mode = 5'h10;
    step(1, 32'hF000_0010);
    idle(); bus.exc_req = 1; bus.exc_mode = 5'h00;
    step(1, 32'hF000_0010);
    // Priority: entry wins over MSR and flag update
    idle(); bus.exc_req = 1; bus.exc_mode = 5'h13; bus.msr_we = 1; bus.msr_field = 2'b11;
    bus.msr_data = 32'h0000_00DF; bus.flag_we = 1; bus.flag_mask = 4'b1111;
    bus.result = 0; bus.cin = 1; bus.vin = 1;
    step(1, 32'hF000_0093, 1, 32'hF000_0010);
    // Reset mid-request, then eret on an all-zero SPSR falls back to USR
    idle(); rst = 1; bus.exc_req = 1; bus.exc_mode = 5'h12;
    step(1, 32'h0000_00D3, 1, 32'h0);
    idle(); bus.eret = 1;
    step(1, 32'h0000_0010, 1, 32'h0);
    // Z over the full width: only bit 0 set gives Z = 0
    idle(); bus.flag_we = 1; bus.flag_mask = 4'b0100; bus.result = 32'h1;
    step(1, 32'h0000_0010);
    idle(); bus.flag_we = 1; bus.flag_mask = 4'b0100; bus.result = 32'h0;
    step(1, 32'h4000_0010);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      rst             = ($urandom_range(99) < 2);
      bus.exc_req     = ($urandom_range(4) == 0);
      bus.exc_mode    = ($urandom_range(4) == 0) ? 5'($urandom) : modes[$urandom_range(6)];
      bus.exc_fiq_dis = 1'($urandom);
      bus.eret        = ($urandom_range(3) == 0);
      bus.msr_we      = ($urandom_range(2) == 0);
      bus.msr_spsr    = 1'($urandom);
      bus.msr_field   = 2'($urandom);
      bus.msr_data    = $urandom();
      if ($urandom_range(3) != 0) bus.msr_data[4:0] = modes[$urandom_range(6)];
      bus.flag_we     = 1'($urandom);
      bus.flag_mask   = 4'($urandom);
      bus.result      = ($urandom_range(3) == 0) ? '0 : DATA_W'($urandom);
      bus.cin         = 1'($urandom);
      bus.vin         = 1'($urandom);
      step();
    end
    idle();
    step();
    stim_done = 1'b1;
  end

  initial begin
    fork
      begin
        wait (stim_done);
        repeat (3) @(negedge clk);
      end
      begin
        #200000;
        n_cmp++; n_bad++;
        $display("FAIL timeout got=%0d expected=%0d", edge_cnt, 0);
      end
    join_any
    disable fork;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got=%0d expected=%0d", q.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
